gpu_net_tx_arbiter: RTL
=======================

# gpu_net_tx_arbiter

Round-robin scheduler that shares the GPU's single 16-bit network-interface transmit port among `NUM_REQ` on-GPU packet sources, such as the AXI master sequencer, slave completion logic and test traffic. Each source gets a one-entry holding slot. The arbiter picks among occupied slots in round-robin order and drives the `net_data_out`/`net_valid_out`/`net_ready_in` handshake toward the network interface, sustaining one packet per cycle. Self-addressed packets are filtered and counted.

## Interface
- `GPU_ID`, 32: identifier of this GPU; compared against packet dest field `[15:10]` (low 6 bits of `GPU_ID`).
- `NUM_REQ`, 4: number of requester lanes; must be ≥ 2.
- `IDX_W`, `$clog2(NUM_REQ)`: lane index width.

Ports:
- `ACLK` in 1: clock.
- `ARESETn` in 1: reset, asynchronous, active-low.
- `req_valid` in `NUM_REQ`: per-lane packet valid.
- `req_data` in `16*NUM_REQ`: lane i packet at `[16i+15:16i]`, format `{dest[5:0], payload[9:0]}`.
- `req_ready` out `NUM_REQ`: per-lane ready; equals `~slot_valid`.
- `net_data_out` out 16: packet toward the network interface.
- `net_valid_out` out 1: packet valid.
- `net_ready_in` in 1: network interface ready.
- `grant_id` out `IDX_W`: lane whose packet is on `net_data_out`.
- `drop_count` out 16: saturating count of filtered self-addressed packets.
- `busy` out 1: high when any slot is occupied or `net_valid_out` is high.

## Operation
- **Reset values:**
  - `net_data_out` = 0, `net_valid_out` = 0, `grant_id` = 0, `drop_count` = 0, `busy` = 0.
  - All slots are empty, so `req_ready` is all ones.
  - `rr_ptr` = 0; FSM is in IDLE.
- **Lane accept:** a lane accepts when `req_valid[i] && req_ready[i]` at a posedge.
  - The packet loads into `slot_data[i]` and `slot_valid[i]` is set.
  - `req_ready[i]` comes from a register only. A slot therefore never loads and frees in the same cycle.
- **Self filter:** if the dest field equals `GPU_ID[5:0]`, the packet is accepted but not stored, and `drop_count` increments.
  - When k lanes drop in the same cycle, `drop_count` adds k.
  - `drop_count` saturates at `16'hFFFF`.
- **Round-robin pick:** select the first occupied slot scanning `rr_ptr`, `rr_ptr+1`, … modulo `NUM_REQ`.
  - On grant: the slot is cleared, `grant_id` = lane, and `rr_ptr` = lane+1 (wrapping `NUM_REQ-1` → 0).
- **FSM:**
  - **IDLE:** `net_valid_out` = 0. If any slot is valid, grant, load `net_data_out`, and go to SEND.
  - **SEND:** `net_valid_out` = 1 and `net_data_out`/`grant_id` are held stable while `net_ready_in` = 0.
    - On `net_ready_in` = 1 with any slot valid: grant the next lane in the same cycle and stay in SEND.
    - On `net_ready_in` = 1 with no slot valid: go to IDLE.
- **Reset mid-operation:** pending and in-flight packets are discarded; all outputs return to their reset values asynchronously.

## Timing
- A transfer occurs at a posedge with `net_valid_out && net_ready_in`.
- **Latency:**
  - Request handshake at edge N → slot valid after N → granted at edge N+1 (from IDLE) → `net_valid_out` high after N+1. Two cycles total.
  - The freed lane may present again on the cycle after grant.
- **Throughput:** with `net_ready_in` held at 1 and all lanes full, one packet transfers per cycle, with lanes rotating 0,1,2,3,0,…
- `net_valid_out` never drops without a transfer; `net_data_out` never changes without a transfer.
- A lane refill and a grant of a different lane in the same cycle are independent.
- **Fairness:** a continuously requesting lane waits at most `NUM_REQ-1` grants.

## Configuration
- **`NET_ARB_DROP_SELF_EN` defined:** the self filter is active as described in Operation.
- **`NET_ARB_DROP_SELF_EN` undefined:**
  - Self-addressed packets are stored and forwarded like any other packet.
  - `drop_count` is tied to 0 and its counter logic is not built.

## Test plan
All scenarios use `GPU_ID` = 32 and `NUM_REQ` = 4.
- **Single packet:** reset, then lane 2 sends `16'h8523` with `net_ready_in` = 1 → `net_valid_out` rises 2 cycles after the handshake, `net_data_out` = `16'h8523`, `grant_id` = 2, then IDLE and `busy` = 0.
- **Full rotation:** all 4 lanes pre-loaded, `net_ready_in` = 1 → 4 consecutive transfers with `grant_id` 0,1,2,3, no bubbles, and `rr_ptr` wraps to 0.
- **Backpressure:** `net_ready_in` = 0 for 10 cycles during SEND → `net_data_out`/`grant_id` are stable, `req_ready` of the granted lane = 1, and the packet transfers on the first ready cycle.
- **Self filter (macro on):**
  - Lanes 0 and 1 send dest 32 (`16'h8001`) in the same cycle → `drop_count` = 2, `net_valid_out` stays 0.
  - Saturation check: preload `drop_count` to `16'hFFFF` via 65535 drops, then one more → stays `16'hFFFF`.
- **Macro off:** same stimulus as the self-filter scenario → both packets forwarded in order 0, 1, and `drop_count` = 0.
- **Reset mid-SEND:** assert `ARESETn` = 0 while `net_valid_out` = 1 → `net_valid_out` = 0 immediately, all `req_ready` = 1, and no stale packet appears after release.

Source files
------------

// File: rtl/gpu_net_tx_arbiter.sv
// Round-robin arbiter sharing one 16-bit network transmit port among NUM_REQ one-slot sources.
// Define NET_ARB_DROP_SELF_EN to filter and count packets addressed to this GPU.
module gpu_net_tx_arbiter #(
    parameter int unsigned GPU_ID  = 32,
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned IDX_W   = $clog2(NUM_REQ)
) (
    input  logic                    ACLK,
    input  logic                    ARESETn,
    input  logic [NUM_REQ-1:0]      req_valid,
    input  logic [16*NUM_REQ-1:0]   req_data,
    output logic [NUM_REQ-1:0]      req_ready,
    output logic [15:0]             net_data_out,
    output logic                    net_valid_out,
    input  logic                    net_ready_in,
    output logic [IDX_W-1:0]        grant_id,
    output logic [15:0]             drop_count,
    output logic                    busy
);

    typedef enum logic [0:0] {StIdle, StSend} state_e;

    state_e                    state_q, state_d;
    logic [NUM_REQ-1:0]        slot_valid_q, slot_valid_d;
    logic [NUM_REQ-1:0][15:0]  slot_data_q, slot_data_d;
    logic [IDX_W-1:0]          rr_ptr_q, rr_ptr_d;
    logic [15:0]               data_q, data_d;
    logic [IDX_W-1:0]          grant_q, grant_d;

    logic [NUM_REQ-1:0]        accept, drop, store;
    logic                      any_valid, do_grant;
    logic [IDX_W-1:0]          pick;

    assign accept = req_valid & ~slot_valid_q;
    assign store  = accept & ~drop;

`ifdef NET_ARB_DROP_SELF_EN
    localparam logic [5:0] SelfDest = 6'(GPU_ID);

    logic [15:0] drop_q, drop_d;
    logic [16:0] drop_sum;

    always_comb begin
        drop = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            drop[i] = accept[i] && (req_data[16*i+10 +: 6] == SelfDest);
        end
    end

    // Multiple same-cycle drops add together; the total clamps at all-ones.
    always_comb begin
        drop_sum = {1'b0, drop_q};
        for (int i = 0; i < NUM_REQ; i++) begin
            drop_sum = drop_sum + 17'(drop[i]);
        end
        drop_d = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) drop_q <= '0;
        else          drop_q <= drop_d;
    end

    assign drop_count = drop_q;
`else
    assign drop       = '0;
    assign drop_count = '0;
`endif

    // First occupied slot at or after rr_ptr, modulo NUM_REQ.
    always_comb begin
        int unsigned idx;
        any_valid = 1'b0;
        pick      = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            idx = int'(rr_ptr_q) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (!any_valid && slot_valid_q[idx]) begin
                any_valid = 1'b1;
                pick      = IDX_W'(idx);
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        do_grant = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (any_valid) begin
                    do_grant = 1'b1;
                    state_d  = StSend;
                end
            end
            StSend: begin
                if (net_ready_in) begin
                    if (any_valid) do_grant = 1'b1;
                    else           state_d  = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        data_d   = data_q;
        grant_d  = grant_q;
        rr_ptr_d = rr_ptr_q;
        if (do_grant) begin
            data_d   = slot_data_q[pick];
            grant_d  = pick;
            rr_ptr_d = (pick == IDX_W'(NUM_REQ - 1)) ? '0 : pick + 1'b1;
        end
    end

    // A slot only loads while empty and only grants while full, so the two never collide.
    always_comb begin
        slot_valid_d = slot_valid_q;
        slot_data_d  = slot_data_q;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (do_grant && pick == IDX_W'(i)) slot_valid_d[i] = 1'b0;
            if (store[i]) begin
                slot_valid_d[i] = 1'b1;
                slot_data_d[i]  = req_data[16*i +: 16];
            end
        end
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state_q      <= StIdle;
            slot_valid_q <= '0;
            slot_data_q  <= '0;
            rr_ptr_q     <= '0;
            data_q       <= '0;
            grant_q      <= '0;
        end else begin
            state_q      <= state_d;
            slot_valid_q <= slot_valid_d;
            slot_data_q  <= slot_data_d;
            rr_ptr_q     <= rr_ptr_d;
            data_q       <= data_d;
            grant_q      <= grant_d;
        end
    end

    assign req_ready     = ~slot_valid_q;
    assign net_valid_out = (state_q == StSend);
    assign net_data_out  = data_q;
    assign grant_id      = grant_q;
    assign busy          = (|slot_valid_q) || (state_q == StSend);

endmodule
